williams_nvram_arbiter: RTL and testbench

//  Shares the single port of the 1K x 4 CMOS (high-score/settings) RAM between the Williams CPU
//  and the HPS ioctl load/save path. The CPU always has priority; HPS byte transfers are held off

---
 rtl/williams_nvram_arbiter_pkg.sv | 5 +
 rtl/williams_nvram_arbiter_if.sv | 32 +++
 rtl/williams_nvram_arbiter.sv | 110 +++++++++++
 tb/tb_williams_nvram_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/williams_nvram_arbiter_pkg.sv
// williams_pkg: shared NVRAM arbiter constants and FSM state type
package williams_pkg;
    localparam logic [7:0] NV_INDEX = 8'd4;
    typedef enum logic [1:0] {IDLE, PEND, RD_WAIT, DONE} nv_state_t;
endpackage

// File: rtl/williams_nvram_arbiter_if.sv
// williams_nvram_arbiter_if: CPU, HPS ioctl and CMOS RAM signals of the NVRAM arbiter
interface williams_nvram_arbiter_if #(parameter int AW = 10, parameter int DW = 4);
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          ioctl_download;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          dirty;
    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_din, ioctl_download, ioctl_upload, ioctl_index,
               ioctl_wr, ioctl_rd, ioctl_addr, ioctl_dout, ram_dout,
        input  cpu_dout, ioctl_din, ioctl_wait, ram_addr, ram_din, ram_we, dirty
    );
    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_din, ioctl_download, ioctl_upload, ioctl_index,
               ioctl_wr, ioctl_rd, ioctl_addr, ioctl_dout, ram_dout,
        output cpu_dout, ioctl_din, ioctl_wait, ram_addr, ram_din, ram_we, dirty
    );
endinterface

// File: rtl/williams_nvram_arbiter.sv
// williams_nvram_arbiter: shares the CMOS RAM port between the CPU (priority) and HPS ioctl
module williams_nvram_arbiter
    import williams_pkg::*;
#(
    parameter int         AW       = 10,
    parameter int         DW       = 4,
    parameter logic [7:0] NV_INDEX = williams_pkg::NV_INDEX,
    parameter int         RD_LAT   = 1
) (
    input logic clk_sys,
    input logic reset_n,
    williams_nvram_arbiter_if.slave bus
);
    nv_state_t     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          wr_q, wr_d;
    logic          oor_q, oor_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          wait_q, wait_d;
    logic [7:0]    din_q, din_d;
    logic          dirty_q, dirty_d;
    logic          upl_q, upl_d;
    logic          nv, q_wr, q_rd, grant;
    logic          unused_bits;

    assign unused_bits = ^bus.ioctl_dout;
    assign nv    = bus.ioctl_index == NV_INDEX;
    assign q_wr  = nv & bus.ioctl_download & bus.ioctl_wr;
    assign q_rd  = nv & bus.ioctl_upload & bus.ioctl_rd;
    assign grant = (state_q == PEND) & ~bus.cpu_cs;

    // CPU always owns the port when selecting it; a pending HPS access only fills idle cycles
    always_comb begin
        bus.ram_we   = reset_n & (bus.cpu_cs ? bus.cpu_we : grant & wr_q & ~oor_q);
        bus.ram_addr = grant ? addr_q : bus.cpu_addr;
        bus.ram_din  = grant ? data_q : bus.cpu_din;
        bus.cpu_dout = bus.ram_dout;
    end

    // request FSM next state; out-of-range requests still run the handshake but never touch RAM
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        oor_d   = oor_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        din_d   = din_q;
        case (state_q)
            IDLE: if (q_wr | q_rd) begin
                state_d = PEND;
                wait_d  = 1'b1;
                addr_d  = bus.ioctl_addr[AW-1:0];
                data_d  = bus.ioctl_dout[DW-1:0];
                wr_d    = q_wr;
                oor_d   = (bus.ioctl_addr >> AW) != 25'd0;
            end
            PEND: if (!bus.cpu_cs) begin
                state_d = wr_q ? DONE : RD_WAIT;
                cnt_d   = 2'd0;
            end
            RD_WAIT: if (cnt_q == 2'(RD_LAT - 1)) begin
                state_d = DONE;
                din_d   = oor_q ? 8'hFF : 8'(bus.ram_dout);
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
            default: begin
                state_d = IDLE;
                wait_d  = 1'b0;
            end
        endcase
        upl_d   = bus.ioctl_upload;
        dirty_d = (bus.cpu_cs & bus.cpu_we) |
                  (dirty_q & ~(nv & ((upl_q & ~bus.ioctl_upload) | bus.ioctl_download)));
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            cnt_q   <= 2'd0;
            wait_q  <= 1'b0;
            din_q   <= 8'hFF;
            dirty_q <= 1'b0;
            upl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            oor_q   <= oor_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            din_q   <= din_d;
            dirty_q <= dirty_d;
            upl_q   <= upl_d;
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.ioctl_din  = din_q;
    assign bus.dirty      = dirty_q;
endmodule

// File: tb/tb_williams_nvram_arbiter.sv
// tb_williams_nvram_arbiter: vector table plus directed sequences for the NVRAM arbiter
module tb_williams_nvram_arbiter;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [3:0] mem [1024];

    williams_nvram_arbiter_if #(.AW(10), .DW(4)) bus ();
    williams_nvram_arbiter #(.AW(10), .DW(4), .NV_INDEX(8'd4), .RD_LAT(1)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk_sys = ~clk_sys;

    // behavioural CMOS RAM, one cycle read latency
    always @(posedge clk_sys) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    typedef struct {
        logic cs, we; logic [9:0] ca; logic [3:0] cd;
        logic dl, ul; logic [7:0] idx; logic wr, rd; logic [24:0] ia; logic [7:0] id;
        logic ewe; logic [9:0] eaddr; logic ewait; logic [7:0] edin; logic edirty;
    } vec_t;
    vec_t tbl [16];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_din = 0;
        bus.ioctl_download = 0; bus.ioctl_upload = 0; bus.ioctl_index = 0;
        bus.ioctl_wr = 0; bus.ioctl_rd = 0; bus.ioctl_addr = 0; bus.ioctl_dout = 0;
    endtask

    task automatic wait_count(output int n, output logic we_seen);
        n = 0;
        we_seen = 0;
        while (bus.ioctl_wait && n < 40) begin
            if (bus.ram_we) we_seen = 1;
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        logic we_seen;
        foreach (mem[i]) mem[i] = 4'h0;
        bus.ram_dout = 4'h0;
        idle_in();
        //          cs we ca cd dl ul idx wr rd ia id | we addr wait din dirty
        tbl[0]  = '{0,0,10'd0,4'h0, 0,0,8'd0,0,0,25'd0,8'h00, 0,10'd0,0,8'hFF,0};
        tbl[1]  = '{1,1,10'd7,4'h9, 0,0,8'd0,0,0,25'd0,8'h00, 1,10'd7,0,8'hFF,1};
        tbl[2]  = '{1,0,10'd8,4'h0, 0,0,8'd0,0,0,25'd0,8'h00, 0,10'd8,0,8'hFF,1};
        tbl[3]  = '{0,0,10'd0,4'h0, 1,0,8'd4,1,0,25'd7,8'h35, 0,10'd0,1,8'hFF,0};
        tbl[4]  = '{0,0,10'd0,4'h0, 1,0,8'd4,0,0,25'd0,8'h00, 1,10'd7,1,8'hFF,0};
        tbl[5]  = '{0,0,10'd0,4'h0, 1,0,8'd4,0,0,25'd0,8'h00, 0,10'd0,0,8'hFF,0};
        tbl[6]  = '{0,0,10'd0,4'h0, 1,0,8'd3,1,0,25'd7,8'h00, 0,10'd0,0,8'hFF,0};
        tbl[7]  = '{0,0,10'd0,4'h0, 0,0,8'd4,1,0,25'd7,8'h00, 0,10'd0,0,8'hFF,0};
        tbl[8]  = '{0,0,10'd0,4'h0, 0,1,8'd4,0,1,25'd7,8'h00, 0,10'd0,1,8'hFF,0};
        tbl[9]  = '{0,0,10'd0,4'h0, 0,1,8'd4,0,0,25'd0,8'h00, 0,10'd7,1,8'hFF,0};
        tbl[10] = '{0,0,10'd0,4'h0, 0,1,8'd4,0,0,25'd0,8'h00, 0,10'd0,1,8'h05,0};
        tbl[11] = '{1,1,10'd8,4'h1, 0,1,8'd4,0,0,25'd0,8'h00, 1,10'd8,0,8'h05,1};
        tbl[12] = '{0,0,10'd0,4'h0, 0,0,8'd4,0,0,25'd0,8'h00, 0,10'd0,0,8'h05,0};
        tbl[13] = '{0,0,10'd0,4'h0, 1,1,8'd4,1,1,25'd9,8'hFC, 0,10'd0,1,8'h05,0};
        tbl[14] = '{0,0,10'd0,4'h0, 1,1,8'd4,0,0,25'd0,8'h00, 1,10'd9,1,8'h05,0};
        tbl[15] = '{0,0,10'd0,4'h0, 0,0,8'd4,0,0,25'd0,8'h00, 0,10'd0,0,8'h05,0};

        // reset values, with the CPU trying to write throughout reset
        bus.cpu_cs = 1; bus.cpu_we = 1;
        #1;
        tick();
        tick();
        chk("reset_ram_we", 32'(bus.ram_we), 0);
        chk("reset_wait", 32'(bus.ioctl_wait), 0);
        chk("reset_din", 32'(bus.ioctl_din), 32'hFF);
        chk("reset_dirty", 32'(bus.dirty), 0);
        chk("reset_state", 32'(dut.state_q), 32'(williams_pkg::IDLE));
        idle_in();
        reset_n = 1;
        tick();

        for (int i = 0; i < 16; i++) begin
            bus.cpu_cs = tbl[i].cs; bus.cpu_we = tbl[i].we;
            bus.cpu_addr = tbl[i].ca; bus.cpu_din = tbl[i].cd;
            bus.ioctl_download = tbl[i].dl; bus.ioctl_upload = tbl[i].ul;
            bus.ioctl_index = tbl[i].idx; bus.ioctl_wr = tbl[i].wr; bus.ioctl_rd = tbl[i].rd;
            bus.ioctl_addr = tbl[i].ia; bus.ioctl_dout = tbl[i].id;
            #1;
            chk($sformatf("row%0d_ram_we", i), 32'(bus.ram_we), 32'(tbl[i].ewe));
            chk($sformatf("row%0d_ram_addr", i), 32'(bus.ram_addr), 32'(tbl[i].eaddr));
            tick();
            chk($sformatf("row%0d_wait", i), 32'(bus.ioctl_wait), 32'(tbl[i].ewait));
            chk($sformatf("row%0d_din", i), 32'(bus.ioctl_din), 32'(tbl[i].edin));
            chk($sformatf("row%0d_dirty", i), 32'(bus.dirty), 32'(tbl[i].edirty));
        end
        idle_in();
        tick();

        // full image download with an idle CPU: every byte holds wait for two cycles
        bad = 0;
        bus.ioctl_download = 1; bus.ioctl_index = 8'd4;
        for (int i = 0; i < 1024; i++) begin
            bus.ioctl_wr = 1; bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'(8'h0A + i);
            tick();
            bus.ioctl_wr = 0;
            wait_count(n, we_seen);
            if (n != 2) bad++;
        end
        chk("download_wait_cycles_bad", 32'(bad), 0);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] b;
            b = 8'(8'h0A + i);
            if (mem[i] !== b[3:0]) bad++;
        end
        chk("download_words_bad", 32'(bad), 0);
        idle_in();
        tick();

        // out-of-range read returns FF, no RAM write, wait released
        bus.ioctl_upload = 1; bus.ioctl_index = 8'd4; bus.ioctl_rd = 1; bus.ioctl_addr = 25'd2048;
        tick();
        bus.ioctl_rd = 0;
        wait_count(n, we_seen);
        chk("oor_rd_wait_cycles", 32'(n), 3);
        chk("oor_rd_din", 32'(bus.ioctl_din), 32'hFF);
        chk("oor_rd_no_we", 32'(we_seen), 0);
        bus.ioctl_upload = 0;
        tick();
        // out-of-range write is dropped
        bus.ioctl_download = 1; bus.ioctl_wr = 1; bus.ioctl_addr = 25'd1027; bus.ioctl_dout = 8'h01;
        tick();
        bus.ioctl_wr = 0;
        wait_count(n, we_seen);
        chk("oor_wr_wait_cycles", 32'(n), 2);
        chk("oor_wr_no_we", 32'(we_seen), 0);
        chk("oor_wr_word3", 32'(mem[3]), 32'hD);
        idle_in();
        tick();

        // upload of word 5 while the CPU holds the port for 10 cycles
        bus.ioctl_upload = 1; bus.ioctl_index = 8'd4; bus.ioctl_rd = 1; bus.ioctl_addr = 25'd5;
        tick();
        bus.ioctl_rd = 0;
        n = 0;
        while (bus.ioctl_wait && n < 40) begin
            n++;
            bus.cpu_cs = (n <= 10);
            tick();
        end
        chk("upload_stall_wait_cycles", 32'(n), 13);
        chk("upload_stall_din", 32'(bus.ioctl_din), 32'h0F);
        idle_in();
        tick();

        // CPU and HPS write the same word in the same cycle: CPU first, HPS last
        bus.cpu_cs = 1; bus.cpu_we = 1; bus.cpu_addr = 10'd3; bus.cpu_din = 4'h7;
        bus.ioctl_download = 1; bus.ioctl_index = 8'd4; bus.ioctl_wr = 1;
        bus.ioctl_addr = 25'd3; bus.ioctl_dout = 8'hF2;
        #1;
        chk("collide_cpu_din", 32'(bus.ram_din), 32'h7);
        chk("collide_cpu_we", 32'(bus.ram_we), 1);
        tick();
        chk("collide_dirty_set_wins", 32'(bus.dirty), 1);
        bus.cpu_cs = 0; bus.cpu_we = 0; bus.ioctl_wr = 0;
        #1;
        chk("collide_hps_we", 32'(bus.ram_we), 1);
        chk("collide_hps_din", 32'(bus.ram_din), 32'h2);
        chk("collide_hps_addr", 32'(bus.ram_addr), 32'd3);
        tick();
        tick();
        chk("collide_word3", 32'(mem[3]), 32'h2);
        idle_in();
        tick();

        // dirty tracking across upload end
        bus.cpu_cs = 1; bus.cpu_we = 1; bus.cpu_addr = 10'd100; bus.cpu_din = 4'h3;
        tick();
        bus.cpu_cs = 0; bus.cpu_we = 0;
        chk("dirty_after_cpu_wr", 32'(bus.dirty), 1);
        bus.ioctl_index = 8'd4; bus.ioctl_upload = 1;
        tick();
        chk("dirty_during_upload", 32'(bus.dirty), 1);
        bus.ioctl_upload = 0;
        tick();
        chk("dirty_upload_end", 32'(bus.dirty), 0);
        bus.ioctl_upload = 1;
        tick();
        bus.ioctl_upload = 0; bus.cpu_cs = 1; bus.cpu_we = 1;
        tick();
        bus.cpu_cs = 0; bus.cpu_we = 0;
        chk("dirty_set_on_upload_end", 32'(bus.dirty), 1);

        // reset asserted while a read sits in RD_WAIT
        bus.ioctl_upload = 1; bus.ioctl_rd = 1; bus.ioctl_addr = 25'd5;
        tick();
        bus.ioctl_rd = 0;
        tick();
        chk("pre_reset_state", 32'(dut.state_q), 32'(williams_pkg::RD_WAIT));
        reset_n = 0; bus.cpu_cs = 1; bus.cpu_we = 1;
        #1;
        chk("rst_ram_we", 32'(bus.ram_we), 0);
        tick();
        chk("rst_wait", 32'(bus.ioctl_wait), 0);
        chk("rst_din", 32'(bus.ioctl_din), 32'hFF);
        chk("rst_dirty", 32'(bus.dirty), 0);
        chk("rst_state", 32'(dut.state_q), 32'(williams_pkg::IDLE));
        idle_in();
        reset_n = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
